// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset sequencer.
// Holds the FSM state encoding, counter widths and a saturating increment
// helper used for the restart counter. No ports.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam int RESTART_W  = 8;
    localparam int WAIT_CNT_W = 16;
    localparam int GAP_CNT_W  = 8;

    function automatic logic [RESTART_W-1:0] sat_inc(input logic [RESTART_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Bundle of the sequencer's request/status signals.
// Handshake: soft_reset_req is a level sampled on every rising clk edge
// (no ready/ack); reset_out, ready and restart_cnt are registered outputs
// valid at all times. dbg_state / dbg_rst_sync expose internals for checkers.
//   master : drives soft_reset_req, observes everything else
//   slave  : the sequencer itself
interface pll_reset_sequencer_if #(
    parameter int RST_NUM = 3
);
    import pll_reset_pkg::*;

    logic                 soft_reset_req;
    logic [RST_NUM-1:0]   reset_out;
    logic                 ready;
    logic [RESTART_W-1:0] restart_cnt;
    state_t               dbg_state;
    logic                 dbg_rst_sync;

    modport master (
        output soft_reset_req,
        input  reset_out, ready, restart_cnt, dbg_state, dbg_rst_sync
    );

    modport slave (
        input  soft_reset_req,
        output reset_out, ready, restart_cnt, dbg_state, dbg_rst_sync
    );

endinterface

// File: rtl/reset_synchronizer.sv
// Async-assert, sync-deassert reset synchronizer.
// Ports:
//   i_clk            destination clock
//   i_rst            asynchronous active-high reset
//   o_rst_sync       synchronized reset, low after SYNC_STAGES clean edges
//   o_rst_sync_nxt   value o_rst_sync takes at the next edge, so a consumer
//                    can change state on the very edge the reset deasserts
module reset_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_rst_sync,
    output logic o_rst_sync_nxt
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign o_rst_sync     = r_chain[SYNC_STAGES-1];
    assign o_rst_sync_nxt = r_chain[SYNC_STAGES-2];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release for one PLL clock domain.
// After the local reset is synchronized, waits LOCK_WAIT edges of stable
// lock, then releases reset_out[0..RST_NUM-1] one by one, STAGE_GAP edges
// apart. A soft request reruns the sequence from the lock wait.
// Ports:
//   clk    PLL output clock
//   reset  asynchronous active-high reset (not-locked OR board reset)
//   bus    slave side: soft_reset_req in; reset_out, ready, restart_cnt,
//          debug state and synchronized reset out
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int RST_NUM     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_WAIT   = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pll_reset_sequencer_if.slave  bus
);

    localparam int STAGE_W = $clog2(RST_NUM + 1);

    logic                  w_rst_sync;
    logic                  w_rst_sync_nxt;

    state_t                r_state,       w_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt,    w_wait_cnt;
    logic [GAP_CNT_W-1:0]  r_gap_cnt,     w_gap_cnt;
    logic [STAGE_W-1:0]    r_stage,       w_stage;
    logic [RST_NUM-1:0]    r_reset_out,   w_reset_out;
    logic                  r_ready,       w_ready;
    logic [RESTART_W-1:0]  r_restart_cnt, w_restart_cnt;

    reset_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk          (clk),
        .i_rst          (reset),
        .o_rst_sync     (w_rst_sync),
        .o_rst_sync_nxt (w_rst_sync_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= SYNC;
            r_wait_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_stage       <= '0;
            r_reset_out   <= '1;
            r_ready       <= 1'b0;
            r_restart_cnt <= '0;
        end else begin
            r_state       <= w_state;
            r_wait_cnt    <= w_wait_cnt;
            r_gap_cnt     <= w_gap_cnt;
            r_stage       <= w_stage;
            r_reset_out   <= w_reset_out;
            r_ready       <= w_ready;
            r_restart_cnt <= w_restart_cnt;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_wait_cnt    = r_wait_cnt;
        w_gap_cnt     = r_gap_cnt;
        w_stage       = r_stage;
        w_reset_out   = r_reset_out;
        w_ready       = r_ready;
        w_restart_cnt = r_restart_cnt;

        case (r_state)
            SYNC: begin
                // Leave on the edge where the synchronized reset drops.
                if (!w_rst_sync_nxt) begin
                    w_state    = WAIT;
                    w_wait_cnt = '0;
                end
            end
            WAIT: begin
                if (r_wait_cnt == WAIT_CNT_W'(LOCK_WAIT - 1)) begin
                    w_reset_out[0] = 1'b0;
                    w_wait_cnt     = '0;
                    w_gap_cnt      = '0;
                    if (RST_NUM == 1) begin
                        w_ready = 1'b1;
                        w_state = RUN;
                        w_stage = '0;
                    end else begin
                        w_state = RELEASE;
                        w_stage = STAGE_W'(1);
                    end
                end else begin
                    w_wait_cnt = r_wait_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (r_gap_cnt == GAP_CNT_W'(STAGE_GAP - 1)) begin
                    // Loop avoids an index narrower/wider than reset_out.
                    for (int i = 0; i < RST_NUM; i++) begin
                        if (i == int'(r_stage)) w_reset_out[i] = 1'b0;
                    end
                    w_gap_cnt = '0;
                    if (int'(r_stage) == RST_NUM - 1) begin
                        w_ready = 1'b1;
                        w_state = RUN;
                        w_stage = '0;
                    end else begin
                        w_stage = r_stage + 1'b1;
                    end
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end
            RUN: begin
            end
            default: begin
                w_state = SYNC;
            end
        endcase

        // A soft request overrides any release scheduled for this edge.
        if (bus.soft_reset_req && (r_state != SYNC)) begin
            w_state     = WAIT;
            w_wait_cnt  = '0;
            w_gap_cnt   = '0;
            w_stage     = '0;
            w_reset_out = '1;
            w_ready     = 1'b0;
            if (r_state == RUN) w_restart_cnt = sat_inc(r_restart_cnt);
        end
    end

    assign bus.reset_out    = r_reset_out;
    assign bus.ready        = r_ready;
    assign bus.restart_cnt  = r_restart_cnt;
    assign bus.dbg_state    = r_state;
    assign bus.dbg_rst_sync = w_rst_sync;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the PLL clock-source wrapper, one instance per generated clock domain.
- Clocked by one PLL output clock; its asynchronous reset is driven by the PLL's active-high not-locked reset, ORed externally with any board reset.
- Produces a glitch-free, synchronously deasserted reset that is released only after lock has been stable for a programmable time.
- Releases RST_NUM reset outputs in a staged order, spaced in time, so that downstream logic (NoC routers, then tiles, then peripherals) comes out of reset in sequence.

Parameters:
- RST_NUM, 3, number of sequenced reset outputs (1-8); output 0 releases first.
- SYNC_STAGES, 2, flip-flop depth of the reset-deassertion synchronizer (2-4).
- LOCK_WAIT, 16, clock cycles of stable lock before reset_out[0] releases (1-65535).
- STAGE_GAP, 4, clock cycles between consecutive output releases (1-255).

Ports:
- clk, input, 1, PLL output clock for this domain.
- reset, input, 1, asynchronous active-high reset (PLL not-locked and/or external reset).
- soft_reset_req, input, 1, synchronous active-high request to rerun the release sequence.
- reset_out, output, RST_NUM, active-high sequenced resets; bit i is released i-th.
- ready, output, 1, high when every reset_out bit is deasserted.
- restart_cnt, output, 8, saturating count of soft_reset_req-triggered restarts.

Behaviour:
- **Reset values.** While reset=1, asynchronously and immediately:
  - reset_out = all ones, ready=0, restart_cnt=0, state=SYNC;
  - counters = 0; synchronizer chain = all ones.
- **Synchronizer.** rst_sync asserts asynchronously with reset and deasserts only after SYNC_STAGES rising clk edges with reset=0.
- **Edge numbering.** Edge 1 is the first rising edge after reset falls.
- **States.**
  - SYNC: waits for rst_sync=0. It goes low after edge SYNC_STAGES, and the FSM moves to WAIT at that same edge.
  - WAIT: a 16-bit counter counts edges. reset_out[0] deasserts after edge SYNC_STAGES+LOCK_WAIT; the FSM then enters RELEASE with the stage index at 1.
  - RELEASE: reset_out[i] deasserts after edge SYNC_STAGES+LOCK_WAIT+i*STAGE_GAP. After the last bit deasserts, ready=1 on that same edge and the FSM enters RUN.
  - If RST_NUM=1, the FSM goes WAIT to RUN directly and ready rises with reset_out[0].
  - RUN: holds all outputs low.
- **Release order.** Outputs deassert strictly in order and never re-assert except on reset or soft_reset_req. reset_out bits are registered, so there is no combinational path from the counters.
- **soft_reset_req.**
  - It is sampled at each edge in the WAIT, RELEASE and RUN states.
  - If soft_reset_req=1 at edge E, then after E: reset_out = all ones, ready=0, counters cleared, state=WAIT.
  - restart_cnt increments only when the request hits in RUN, saturating at 255.
  - While the request stays high, the FSM is held in WAIT with the counter at 0.
  - Counting resumes on the first edge with req=0 and counts that edge as 1. reset_out[0] is released LOCK_WAIT edges after the request falls, and the later bits follow at STAGE_GAP spacing.
  - In SYNC the request is ignored.
- **Async reset mid-sequence** (PLL loses lock in any state): all outputs reassert immediately without waiting for a clock edge. The full sequence, including synchronization, restarts after reset falls; restart_cnt clears.
- **Simultaneous events.** reset dominates soft_reset_req. A soft_reset_req arriving on the same edge a stage would release takes priority: no release happens on that edge.
- **Width rules.** The LOCK_WAIT counter is 16 bits, the gap counter 8 bits, and the stage index is clog2(RST_NUM+1) bits. Counters never wrap; they are cleared on each transition.

Decomposition:
- **Shared package** (pll_reset_pkg) holds:
  - the FSM state encoding constants: SYNC=2'd0, WAIT=2'd1, RELEASE=2'd2, RUN=2'd3;
  - the restart_cnt width (8) and the counter widths.
- **Sub-module reset_synchronizer** provides async-assert, sync-deassert over SYNC_STAGES flops.
  - It is kept separate because the clock-source directory reuses it for other domains.
  - Its outputs are the only reset used by the FSM flops, apart from the async clear.

Test Plan:
1. **Power-up with defaults.** Drop reset at t0 → reset_out[0] falls after edge 18, [1] after edge 22, [2] after edge 26; ready rises after edge 26; restart_cnt=0.
2. **Lock loss in RUN.** Pulse reset high for 3 ns mid-cycle → reset_out=3'b111 and ready=0 immediately, before the next edge. After reset falls, the same 18/22/26 timing repeats from the new edge 1.
3. **Soft restart.** In RUN, soft_reset_req high for 5 edges (E..E+4) → outputs all ones after E; restart_cnt=1; reset_out[0] falls 16 edges after the request drops, then [1] and [2] at +4 and +8.
4. **Reset during RELEASE.** Assert reset after edge 20 (only bit 0 released) → all bits high asynchronously; no bit releases before edge 18 of the new sequence.
5. **Request colliding with a release edge.** soft_reset_req=1 on edge 22 → reset_out[1] stays high; outputs become 3'b111; restart_cnt unchanged because the FSM was not in RUN.
6. **Minimal configuration.** RST_NUM=1, LOCK_WAIT=1, SYNC_STAGES=2 → reset_out[0] and ready change after edge 3. Also issue 300 soft requests → restart_cnt saturates at 255.
